mux_rr_sched: RTL and testbench



---
 rtl/mux_sched_pkg.sv | 23 ++
 rtl/mux_rr_sched_if.sv | 32 +++
 rtl/mux_rr_sched_rr_pick.sv | 49 ++++
 rtl/mux_rr_sched.sv | 117 +++++++++++
 tb/tb_mux_rr_sched.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux_sched_pkg
// Brief    : Shared constants and FSM state type for the round-robin mux scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_sched_pkg;

   localparam int NUM_REQ = 31;
   localparam int SEL_W   = 5;
   localparam int DATA_W  = 2;

   localparam logic [SEL_W-1:0] LAST_RESET = 5'd30;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_rr_sched_if.sv
//------------------------------------------------------------------------------
// Module   : mux_rr_sched_if
// Brief    : Request, mux-select and tagged capture bundle of the scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mux_rr_sched_if;
   import mux_sched_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [DATA_W-1:0]  mux_out;
   logic [SEL_W-1:0]   sel;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_vld;
   logic [DATA_W-1:0]  cap_data;
   logic [SEL_W-1:0]   cap_src;
   logic               cap_vld;

   modport master (
      input  req, mux_out,
      output sel, gnt, gnt_vld, cap_data, cap_src, cap_vld
   );

   modport slave (
      output req, mux_out,
      input  sel, gnt, gnt_vld, cap_data, cap_src, cap_vld
   );

endinterface

`default_nettype wire

// File: rtl/mux_rr_sched_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Brief    : Combinational round-robin picker: rotate, priority-encode, re-offset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
   import mux_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   output logic [SEL_W-1:0]   idx,
   output logic               found
);

   logic [SEL_W-1:0]   w_start;
   logic [NUM_REQ-1:0] w_rot;
   logic [SEL_W-1:0]   w_pos;
   logic [SEL_W:0]     w_sum;

   assign w_start = (last >= SEL_W'(NUM_REQ-1)) ? '0 : last + 1'b1;

   // w_rot[i] is requester (w_start + i) mod NUM_REQ, so bit 0 has top priority
   always_comb begin
      w_rot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int j;
         j = int'(w_start) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         w_rot[i] = req[j];
      end
   end

   always_comb begin
      w_pos = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (w_rot[i]) w_pos = SEL_W'(i);
      end
   end

   assign w_sum = {1'b0, w_start} + {1'b0, w_pos};
   assign idx   = (w_sum >= (SEL_W+1)'(NUM_REQ)) ? SEL_W'(w_sum - (SEL_W+1)'(NUM_REQ))
                                                 : w_sum[SEL_W-1:0];
   assign found = |req;

endmodule

`default_nettype wire

// File: rtl/mux_rr_sched.sv
//------------------------------------------------------------------------------
// Module   : mux_rr_sched
// Brief    : Round-robin owner of the 31:1 mux; captures tagged beats per grant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_rr_sched
   import mux_sched_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
)(
   input  logic           clk,
   input  logic           reset,
   mux_rr_sched_if.master bus
);

   localparam int               c_beat_w    = $clog2(HOLD_CYCLES) + 1;
   localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(HOLD_CYCLES - 1);

   state_t              r_state,    w_state;
   logic [SEL_W-1:0]    r_sel,      w_sel;
   logic [NUM_REQ-1:0]  r_gnt,      w_gnt;
   logic                r_gnt_vld,  w_gnt_vld;
   logic [DATA_W-1:0]   r_cap_data, w_cap_data;
   logic [SEL_W-1:0]    r_cap_src,  w_cap_src;
   logic                r_cap_vld,  w_cap_vld;
   logic [SEL_W-1:0]    r_last,     w_last;
   logic [c_beat_w-1:0] r_beat,     w_beat;

   logic [SEL_W-1:0]    w_pick_idx;
   logic                w_pick_found;

   rr_pick u_rr_pick (
      .req   (bus.req),
      .last  (r_last),
      .idx   (w_pick_idx),
      .found (w_pick_found)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_gnt      <= '0;
         r_gnt_vld  <= 1'b0;
         r_cap_data <= '0;
         r_cap_src  <= '0;
         r_cap_vld  <= 1'b0;
         r_last     <= LAST_RESET;
         r_beat     <= '0;
      end else begin
         r_state    <= w_state;
         r_sel      <= w_sel;
         r_gnt      <= w_gnt;
         r_gnt_vld  <= w_gnt_vld;
         r_cap_data <= w_cap_data;
         r_cap_src  <= w_cap_src;
         r_cap_vld  <= w_cap_vld;
         r_last     <= w_last;
         r_beat     <= w_beat;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_sel      = r_sel;
      w_gnt      = r_gnt;
      w_gnt_vld  = r_gnt_vld;
      w_cap_data = r_cap_data;
      w_cap_src  = r_cap_src;
      w_cap_vld  = 1'b0;
      w_last     = r_last;
      w_beat     = r_beat;

      case (r_state)
         S_IDLE: begin
            w_gnt = '0;
            if (w_pick_found) begin
               w_sel     = w_pick_idx;
               w_gnt     = NUM_REQ'(1) << w_pick_idx;
               w_gnt_vld = 1'b1;
               w_beat    = '0;
               w_state   = S_GRANT;
            end
         end

         S_GRANT: begin
            // A dropped request releases the mux without sampling that edge
            if (bus.req[r_sel]) begin
               w_cap_data = bus.mux_out;
               w_cap_src  = r_sel;
               w_cap_vld  = 1'b1;
               w_beat     = r_beat + 1'b1;
            end
            if (!bus.req[r_sel] || (r_beat == c_beat_last)) begin
               w_gnt     = '0;
               w_gnt_vld = 1'b0;
               w_last    = r_sel;
               w_state   = S_IDLE;
            end
         end

         default: w_state = S_IDLE;
      endcase
   end

   assign bus.sel      = r_sel;
   assign bus.gnt      = r_gnt;
   assign bus.gnt_vld  = r_gnt_vld;
   assign bus.cap_data = r_cap_data;
   assign bus.cap_src  = r_cap_src;
   assign bus.cap_vld  = r_cap_vld;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_rr_sched
// Brief    : Randomised scoreboard bench for mux_rr_sched against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_rr_sched;
   import mux_sched_pkg::*;

   localparam int HOLD = 4;

   logic clk;
   logic reset;
   logic [1:0] inp [NUM_REQ];

   mux_rr_sched_if dif ();

   mux_rr_sched #(.HOLD_CYCLES(HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 31:1 mux; code 31 is the unused default
   always_comb begin
      dif.mux_out = 2'b00;
      for (int i = 0; i < NUM_REQ; i++)
         if (int'(dif.sel) == i) dif.mux_out = inp[i];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: who owns the mux, how many beats it has had, who went last
   typedef struct { logic [1:0] d; int s; } cap_t;
   cap_t q[$];
   int  m_owner = -1;
   int  m_last  = 30;
   int  m_beats = 0;
   bit  exp_gv  = 0;
   bit  exp_cv  = 0;
   int  exp_sel = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_owner = -1; m_last = 30; m_beats = 0;
         exp_gv = 0; exp_cv = 0; exp_sel = 0;
         q.delete();
      end else begin
         exp_cv = 0;
         if (m_owner < 0) begin
            if (dif.req != '0) begin
               bit got;
               got = 0;
               for (int k = 1; k <= NUM_REQ; k++) begin
                  int c;
                  c = (m_last + k) % NUM_REQ;
                  if (!got && dif.req[c]) begin
                     m_owner = c;
                     got = 1;
                  end
               end
               m_beats = 0;
               exp_gv  = 1;
               exp_sel = m_owner;
            end
         end else if (dif.req[m_owner]) begin
            q.push_back('{inp[m_owner], m_owner});
            exp_cv = 1;
            m_beats++;
            if (m_beats == HOLD) begin
               m_last = m_owner; m_owner = -1; exp_gv = 0;
            end
         end else begin
            m_last = m_owner; m_owner = -1; exp_gv = 0;
         end
      end
   end

   bit mon_en = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("gnt_vld", 32'(dif.gnt_vld), 32'(exp_gv));
         chk("cap_vld", 32'(dif.cap_vld), 32'(exp_cv));
         if (dif.sel == 5'd31) chk("sel_not_31", 32'(dif.sel), 32'd30);
         if (dif.gnt_vld) begin
            chk("sel", 32'(dif.sel), 32'(exp_sel));
            chk("gnt", 32'(dif.gnt), 32'(1) << exp_sel);
         end else begin
            chk("gnt_idle", 32'(dif.gnt), 32'd0);
         end
         if (dif.cap_vld) begin
            if (q.size() == 0) begin
               chk("cap_unexpected", 32'(dif.cap_src), 32'hFFFF_FFFF);
            end else begin
               cap_t e;
               e = q.pop_front();
               chk("cap_data", 32'(dif.cap_data), 32'(e.d));
               chk("cap_src",  32'(dif.cap_src),  32'(e.s));
            end
         end
      end
   end

   task automatic wait_caps(input int src, input int n);
      int seen;
      seen = 0;
      for (int t = 0; t < 80 && seen < n; t++) begin
         @(negedge clk);
         if (dif.cap_vld && int'(dif.cap_src) == src) seen++;
      end
      chk("wait_caps_timeout", 32'(seen), 32'(n));
   endtask

   task automatic pulse_reset();
      dif.req = '0;
      reset   = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      dif.req = '0;
      for (int i = 0; i < NUM_REQ; i++) inp[i] = 2'(i);
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      mon_en = 1;

      // idle after reset
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("rst_sel",      32'(dif.sel),      32'd0);
         chk("rst_cap_data", 32'(dif.cap_data), 32'd0);
         chk("rst_cap_src",  32'(dif.cap_src),  32'd0);
      end

      // sole requester 5
      inp[5]  = 2'b10;
      dif.req = 31'(1) << 5;
      repeat (20) @(negedge clk);

      // three requesters with wrap
      dif.req = (31'(1) << 0) | (31'(1) << 3) | (31'(1) << 30);
      repeat (25) @(negedge clk);

      // early drop of requester 3
      pulse_reset();
      dif.req = (31'(1) << 3) | (31'(1) << 7);
      wait_caps(3, 2);
      dif.req = 31'(1) << 7;
      repeat (10) @(negedge clk);
      dif.req = '0;
      repeat (3) @(negedge clk);

      // reset during a grant to 12
      pulse_reset();
      dif.req = 31'(1) << 12;
      wait_caps(12, 2);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_gnt_vld", 32'(dif.gnt_vld), 32'd0);
      reset   = 1'b0;
      dif.req = (31'(1) << 12) | 31'(1);
      begin
         int t;
         t = 0;
         while (!dif.gnt_vld && t < 20) begin
            @(negedge clk);
            t++;
         end
         chk("post_rst_first_grant", 32'(dif.sel), 32'd0);
      end
      repeat (10) @(negedge clk);

      // top requester
      dif.req = 31'(1) << 30;
      repeat (12) @(negedge clk);

      // random traffic
      for (int c = 0; c < 1000; c++) begin
         dif.req = 31'($urandom & $urandom & $urandom);
         for (int i = 0; i < NUM_REQ; i++) inp[i] = 2'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         @(negedge clk);
      end
      reset   = 1'b0;
      dif.req = '0;
      repeat (8) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
